// File: rtl/pressure_abnormality_detector.sv
// Pressure abnormality detector: classifies samples against [LOW_TH, HIGH_TH], raises a registered alarm,
// counts alarm events and keeps a sticky alarm. Define PRESSURE_PERSIST_EN to enable the persistence filter.
module pressure_abnormality_detector #(
  parameter int unsigned DATA_W  = 6,
  parameter int unsigned LOW_TH  = 8,
  parameter int unsigned HIGH_TH = 15,
  parameter int unsigned PERSIST = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] pressureData,
  input  logic              alarm_clr,
  output logic              presureAbnormality,
  output logic              below_low,
  output logic              above_high,
  output logic [CNT_W-1:0]  abnormal_count,
  output logic              sticky_alarm
);

  if (PERSIST < 1 || PERSIST > 15) begin : g_bad_persist
    $error("PERSIST must be in 1..15");
  end

  localparam logic [DATA_W-1:0] LOW_V   = DATA_W'(LOW_TH);
  localparam logic [DATA_W-1:0] HIGH_V  = DATA_W'(HIGH_TH);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic is_low, is_high, is_abn;
  logic alarm_q, alarm_d;
  logic below_q, below_d;
  logic above_q, above_d;
  logic sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic rise;

  assign is_low  = (pressureData < LOW_V);
  assign is_high = (pressureData > HIGH_V);
  assign is_abn  = is_low | is_high;

`ifdef PRESSURE_PERSIST_EN
  localparam logic [3:0] PERSIST_V = 4'(PERSIST);
  logic [3:0] run_q, run_d;

  always_comb begin
    run_d = run_q;
    if (sample_valid) begin
      if (!is_abn)                run_d = '0;
      else if (run_q != PERSIST_V) run_d = run_q + 4'd1;
    end
  end

  assign alarm_d = (run_d == PERSIST_V);

  always_ff @(posedge clk) begin
    if (rst) run_q <= '0;
    else     run_q <= run_d;
  end
`else
  assign alarm_d = sample_valid ? is_abn : alarm_q;
`endif

  assign rise = alarm_d & ~alarm_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    below_d  = below_q;
    above_d  = above_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    if (sample_valid) begin
      below_d = is_low;
      above_d = is_high;
    end
    if (rise && count_q != CNT_MAX) count_d = count_q + 1'b1;
    // A rising alarm outranks a simultaneous software clear.
    if (rise)           sticky_d = 1'b1;
    else if (alarm_clr) sticky_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q  <= 1'b0;
      below_q  <= 1'b0;
      above_q  <= 1'b0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      alarm_q  <= alarm_d;
      below_q  <= below_d;
      above_q  <= above_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  assign presureAbnormality = alarm_q;
  assign below_low          = below_q;
  assign above_high         = above_q;
  assign abnormal_count     = count_q;
  assign sticky_alarm       = sticky_q;

endmodule

// File: tb/tb_pressure_abnormality_detector.sv
// Directed bench for pressure_abnormality_detector; expectations follow PRESSURE_PERSIST_EN
// (persistence 2 when defined, single-sample alarm when undefined).
module tb_pressure_abnormality_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_valid = 1'b0;
  logic [5:0] pressureData = '0;
  logic       alarm_clr = 1'b0;
  logic       presureAbnormality;
  logic       below_low;
  logic       above_high;
  logic [7:0] abnormal_count;
  logic       sticky_alarm;

  int n_checks = 0;
  int n_fails  = 0;

  pressure_abnormality_detector dut (
    .clk                (clk),
    .rst                (rst),
    .sample_valid       (sample_valid),
    .pressureData       (pressureData),
    .alarm_clr          (alarm_clr),
    .presureAbnormality (presureAbnormality),
    .below_low          (below_low),
    .above_high         (above_high),
    .abnormal_count     (abnormal_count),
    .sticky_alarm       (sticky_alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic alarm, input logic below,
                           input logic above, input logic [7:0] cnt, input logic sticky);
    check({tag, ".alarm"},  {31'd0, presureAbnormality}, {31'd0, alarm});
    check({tag, ".below"},  {31'd0, below_low},          {31'd0, below});
    check({tag, ".above"},  {31'd0, above_high},         {31'd0, above});
    check({tag, ".count"},  {24'd0, abnormal_count},     {24'd0, cnt});
    check({tag, ".sticky"}, {31'd0, sticky_alarm},       {31'd0, sticky});
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later, then idle the strobes.
  task automatic step(input logic v, input logic [5:0] d, input logic clr);
    sample_valid = v;
    pressureData = d;
    alarm_clr    = clr;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    alarm_clr    = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    reset_pulse();
    check_all("reset", 0, 0, 0, 8'd0, 0);
    step(1, 6'd8, 0);  check_all("s8",  0, 0, 0, 8'd0, 0);
    step(1, 6'd15, 0); check_all("s15", 0, 0, 0, 8'd0, 0);

`ifdef PRESSURE_PERSIST_EN
    step(1, 6'd1, 0);  check_all("low1a", 0, 1, 0, 8'd0, 0);
    step(1, 6'd1, 0);  check_all("low1b", 1, 1, 0, 8'd1, 1);
    step(1, 6'd7, 0);  check_all("low7_hold", 1, 1, 0, 8'd1, 1);
    step(1, 6'd10, 0); check_all("norm10", 0, 0, 0, 8'd1, 1);
    step(1, 6'd16, 0); check_all("hi16a", 0, 0, 1, 8'd1, 1);
    step(1, 6'd8, 0);  check_all("mid8",  0, 0, 0, 8'd1, 1);
    step(1, 6'd16, 0); check_all("hi16b", 0, 0, 1, 8'd1, 1);
    step(1, 6'd8, 0);  check_all("mid8b", 0, 0, 0, 8'd1, 1);
    step(1, 6'd49, 0); check_all("s49", 0, 0, 1, 8'd1, 1);
    for (int i = 0; i < 3; i++) step(0, 6'd10, 0);
    check_all("gap", 0, 0, 1, 8'd1, 1);
    step(1, 6'd41, 0); check_all("s41", 1, 0, 1, 8'd2, 1);
    step(1, 6'd10, 0); check_all("deassert", 0, 0, 0, 8'd2, 1);
    step(0, 6'd0, 1);  check_all("clr", 0, 0, 0, 8'd2, 0);
    step(1, 6'd1, 0);  check_all("pre_setclr", 0, 1, 0, 8'd2, 0);
    step(1, 6'd1, 1);  check_all("setclr", 1, 1, 0, 8'd3, 1);
    step(1, 6'd10, 0); check_all("norm_b", 0, 0, 0, 8'd3, 1);
    step(1, 6'd32, 0); check_all("s32", 0, 0, 1, 8'd3, 1);
    reset_pulse();     check_all("midrst", 0, 0, 0, 8'd0, 0);
    step(1, 6'd37, 0); check_all("s37", 0, 0, 1, 8'd0, 0);
    step(1, 6'd25, 0); check_all("s25", 1, 0, 1, 8'd1, 1);
    for (int i = 0; i < 254; i++) begin
      step(1, 6'd10, 0);
      step(1, 6'd1, 0);
      step(1, 6'd1, 0);
    end
    check_all("sat255", 1, 1, 0, 8'd255, 1);
    step(1, 6'd10, 0);
    step(1, 6'd1, 0);
    step(1, 6'd1, 0);
    check_all("sat_hold", 1, 1, 0, 8'd255, 1);
`else
    step(1, 6'd21, 0); check_all("s21", 1, 0, 1, 8'd1, 1);
    step(1, 6'd9, 0);  check_all("s9",  0, 0, 0, 8'd1, 1);
    step(1, 6'd1, 0);  check_all("low1", 1, 1, 0, 8'd2, 1);
    step(0, 6'd30, 0); check_all("idle_hold", 1, 1, 0, 8'd2, 1);
    step(1, 6'd2, 0);  check_all("low2_norise", 1, 1, 0, 8'd2, 1);
    step(1, 6'd12, 0); check_all("s12", 0, 0, 0, 8'd2, 1);
    step(0, 6'd0, 1);  check_all("clr", 0, 0, 0, 8'd2, 0);
    step(1, 6'd0, 1);  check_all("setclr", 1, 1, 0, 8'd3, 1);
    step(1, 6'd7, 1);  check_all("clr_while_high", 1, 1, 0, 8'd3, 0);
    step(1, 6'd16, 0); check_all("hi16", 1, 0, 1, 8'd3, 0);
    step(1, 6'd15, 0); check_all("edge15", 0, 0, 0, 8'd3, 0);
    step(1, 6'd7, 0);  check_all("edge7", 1, 1, 0, 8'd4, 1);
    reset_pulse();     check_all("midrst", 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 255; i++) begin
      step(1, 6'd1, 0);
      step(1, 6'd10, 0);
    end
    check_all("sat255", 0, 0, 0, 8'd255, 1);
    step(1, 6'd63, 0); check_all("sat_hold", 1, 0, 1, 8'd255, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
